// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: walks each instruction through fetch, decode, execute, memory and
// writeback with a ready-based memory handshake, timeout faulting and flag-conditioned branches.
`timescale 1ns/1ps
module multicycle_control_unit #(
  parameter int unsigned OP_W        = 4,
  parameter int unsigned ALU_FUNC_W  = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [OP_W-1:0]       instr_op,
  input  logic                  immed_in,
  input  logic                  flag_in,
  input  logic                  flag_z,
  input  logic                  flag_lt,
  input  logic                  flag_gt,
  input  logic                  mem_ready,
  output logic                  ir_load,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic                  w_en,
  output logic [ALU_FUNC_W-1:0] alu_func,
  output logic                  immed_sel,
  output logic                  flag_en,
  output logic                  mem_sel,
  output logic                  mem_en,
  output logic                  read_write,
  output logic [2:0]            state,
  output logic                  retire,
  output logic                  fault
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam logic [OP_W+3:0] OP_MAX = 15;

  localparam logic [3:0] OP_JMP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_BE  = 4'hB;
  localparam logic [3:0] OP_BNE = 4'hC;
  localparam logic [3:0] OP_BLT = 4'hD;
  localparam logic [3:0] OP_BGT = 4'hE;
  localparam logic [3:0] OP_CMP = 4'hF;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StFault  = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             imm_q, imm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [OP_W+3:0]  op_ext;
  logic             op_illegal;
  logic             wait_expired;

  // Widen before comparing so any OP_W works; only the low nibble is ever executed.
  assign op_ext       = {4'b0000, instr_op};
  assign op_illegal   = (op_ext > OP_MAX);
  assign cnt_inc      = cnt_q + CNT_W'(1);
  assign wait_expired = (MEM_TIMEOUT != 0) && !mem_ready && (cnt_inc == CNT_LIMIT);
  assign state        = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      imm_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    imm_d      = imm_q;
    cnt_d      = cnt_q;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    w_en       = 1'b0;
    alu_func   = '0;
    immed_sel  = 1'b0;
    flag_en    = 1'b0;
    mem_sel    = 1'b0;
    mem_en     = 1'b0;
    read_write = 1'b0;
    retire     = 1'b0;
    fault      = 1'b0;

    case (state_q)
      StIdle: begin
        if (en) state_d = StFetch;
      end
      StFetch: begin
        mem_en     = 1'b1;
        read_write = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = StDecode;
        end else if (wait_expired) begin
          state_d = StFault;
        end
      end
      StDecode: begin
        op_d    = op_ext[3:0];
        imm_d   = immed_in;
        state_d = op_illegal ? StFault : StExec;
      end
      StExec: begin
        alu_func  = ALU_FUNC_W'(op_q);
        immed_sel = imm_q;
        case (op_q)
          OP_JMP: begin pc_load = 1'b1;     retire = 1'b1; end
          OP_BE:  begin pc_load = flag_z;   retire = 1'b1; end
          OP_BNE: begin pc_load = !flag_z;  retire = 1'b1; end
          OP_BLT: begin pc_load = flag_lt;  retire = 1'b1; end
          OP_BGT: begin pc_load = flag_gt;  retire = 1'b1; end
          OP_CMP: begin flag_en = 1'b1;     retire = 1'b1; end
          OP_LD, OP_ST: state_d = StMem;
          default: begin
            flag_en = flag_in;
            state_d = StWb;
          end
        endcase
      end
      StMem: begin
        mem_en     = 1'b1;
        mem_sel    = 1'b1;
        read_write = (op_q == OP_LD);
        alu_func   = ALU_FUNC_W'(op_q);
        if (mem_ready) begin
          if (op_q == OP_LD) state_d = StWb;
          else               retire  = 1'b1;
        end else if (wait_expired) begin
          state_d = StFault;
        end
      end
      StWb: begin
        w_en     = 1'b1;
        alu_func = ALU_FUNC_W'(op_q);
        retire   = 1'b1;
      end
      StFault: begin
        fault = 1'b1;
      end
      default: begin
        state_d = StFault;
      end
    endcase

    if (retire) state_d = en ? StFetch : StIdle;

    // Ready always wins over the limit: the counter only advances on stalled cycles.
    if ((state_q == StFetch || state_q == StMem) && !mem_ready) cnt_d = cnt_inc;
    if (state_d != state_q && (state_d == StFetch || state_d == StMem)) cnt_d = '0;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: an instruction-level timeline model drives random traffic
// and predicts every output each cycle; directed sequences pin the model with literal values.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  localparam int OP_W    = 5;
  localparam int AW      = 5;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset, en, immed_in, flag_in, flag_z, flag_lt, flag_gt, mem_ready;
  logic [OP_W-1:0] instr_op;
  logic ir_load, pc_inc, pc_load, w_en, immed_sel, flag_en, mem_sel, mem_en, read_write;
  logic retire, fault;
  logic [AW-1:0] alu_func;
  logic [2:0] state;

  multicycle_control_unit #(
    .OP_W        (OP_W),
    .ALU_FUNC_W  (AW),
    .MEM_TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .instr_op   (instr_op),
    .immed_in   (immed_in),
    .flag_in    (flag_in),
    .flag_z     (flag_z),
    .flag_lt    (flag_lt),
    .flag_gt    (flag_gt),
    .mem_ready  (mem_ready),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .w_en       (w_en),
    .alu_func   (alu_func),
    .immed_sel  (immed_sel),
    .flag_en    (flag_en),
    .mem_sel    (mem_sel),
    .mem_en     (mem_en),
    .read_write (read_write),
    .state      (state),
    .retire     (retire),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ir_load, pc_inc, pc_load, w_en;
    logic [AW-1:0] alu_func;
    logic          immed_sel, flag_en, mem_sel, mem_en, read_write;
    logic [2:0]    state;
    logic          retire, fault;
  } outs_t;

  outs_t act_o, exp_o;
  outs_t log_q[$];
  bit    chk_on = 1'b0;
  int    checks = 0;
  int    failures = 0;

  assign act_o = {ir_load, pc_inc, pc_load, w_en, alu_func, immed_sel, flag_en, mem_sel, mem_en,
                  read_write, state, retire, fault};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("outs", 32'(act_o), 32'(exp_o));
      log_q.push_back(act_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1);
  end

  function automatic outs_t zero_o(input logic [2:0] st);
    outs_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  function automatic logic pick_en(input int mode);
    return (mode == 2) ? 1'($urandom) : (mode != 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs that must not influence the outputs in the current cycle.
  task automatic noise();
    mem_ready = 1'($urandom);
    flag_in   = 1'($urandom);
    flag_z    = 1'($urandom);
    flag_lt   = 1'($urandom);
    flag_gt   = 1'($urandom);
    immed_in  = 1'($urandom);
    instr_op  = OP_W'($urandom);
  endtask

  task automatic idle_phase(input bit rand_en);
    for (int i = 0; i < 20; i++) begin
      noise();
      en = rand_en ? ($urandom_range(0, 3) == 0) : 1'b1;
      if (i == 19) en = 1'b1;
      exp_o = zero_o(3'd0);
      step();
      if (en) break;
    end
  endtask

  task automatic fault_phase(input int n);
    outs_t o;
    for (int i = 0; i < n; i++) begin
      noise();
      en = 1'($urandom);
      o = zero_o(3'd7);
      o.fault = 1'b1;
      exp_o = o;
      step();
    end
  endtask

  task automatic do_reset();
    noise();
    reset = 1'b1;
    exp_o = zero_o(3'd0);
    step();
    reset = 1'b0;
  endtask

  // One instruction's timeline. fl = {flag_in, flag_z, flag_lt, flag_gt} during execute.
  // status: 0 retired, 1 faulted, 2 reset asserted during the memory phase.
  task automatic do_instr(input logic [OP_W-1:0] op, input logic imm, input logic [3:0] fl,
                          input int fw, input int mw, input int en_mode, input bit ret_en,
                          input bit rst_mem, output int status);
    outs_t o;
    bit    ret;
    status = 0;
    for (int i = 0; i < 100; i++) begin
      noise();
      en = pick_en(en_mode);
      mem_ready = (i == fw);
      o = zero_o(3'd1);
      o.mem_en = 1'b1;
      o.read_write = 1'b1;
      o.ir_load = mem_ready;
      o.pc_inc = mem_ready;
      exp_o = o;
      step();
      if (i == fw) break;
      if (i + 1 == TIMEOUT) begin status = 1; return; end
    end
    noise();
    en = pick_en(en_mode);
    instr_op = op;
    immed_in = imm;
    exp_o = zero_o(3'd2);
    step();
    if (op > 15) begin status = 1; return; end

    noise();
    {flag_in, flag_z, flag_lt, flag_gt} = fl;
    o = zero_o(3'd3);
    o.alu_func = AW'(op);
    o.immed_sel = imm;
    ret = 1'b1;
    case (op)
      0:       o.pc_load = 1'b1;
      8, 9:    ret = 1'b0;
      11:      o.pc_load = fl[2];
      12:      o.pc_load = !fl[2];
      13:      o.pc_load = fl[1];
      14:      o.pc_load = fl[0];
      15:      o.flag_en = 1'b1;
      default: begin o.flag_en = fl[3]; ret = 1'b0; end
    endcase
    o.retire = ret;
    en = ret ? ret_en : pick_en(en_mode);
    exp_o = o;
    step();
    if (ret) return;

    if (op == 8 || op == 9) begin
      for (int i = 0; i < 100; i++) begin
        noise();
        mem_ready = (i == mw);
        o = zero_o(3'd4);
        o.mem_en = 1'b1;
        o.mem_sel = 1'b1;
        o.read_write = (op == 8);
        o.alu_func = AW'(op);
        o.retire = mem_ready && (op == 9);
        en = o.retire ? ret_en : pick_en(en_mode);
        exp_o = o;
        if (rst_mem && i == 1) begin
          #2;
          chk("pre_reset_mem_state", 32'(act_o.state), 32'd4);
          reset = 1'b1;
          exp_o = zero_o(3'd0);
          #1;
          chk("async_reset_outs", 32'(act_o), 32'd0);
          step();
          status = 2;
          return;
        end
        step();
        if (i == mw) break;
        if (i + 1 == TIMEOUT) begin status = 1; return; end
      end
      if (op == 9) return;
    end

    noise();
    en = ret_en;
    o = zero_o(3'd5);
    o.w_en = 1'b1;
    o.alu_func = AW'(op);
    o.retire = 1'b1;
    exp_o = o;
    step();
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 29);
    if (r == 0) return $urandom_range(4, 6);
    if (r < 4)  return 3;
    return $urandom_range(0, 2);
  endfunction

  initial begin
    int st;
    logic [31:0] bits;
    logic [OP_W-1:0] rop;
    int fw, mw;
    bit re;

    reset = 1'b1;
    en = 1'b0;
    noise();
    #3;
    chk("reset_outs", 32'(act_o), 32'd0);
    exp_o = zero_o(3'd0);
    chk_on = 1'b1;
    step();
    reset = 1'b0;
    idle_phase(1'b0);

    // ADD, flag_in=1, memory always ready
    log_q.delete();
    do_instr(5'h1, 1'b1, 4'b1000, 0, 0, 1, 1'b1, 1'b0, st);
    chk("add_states", 32'({log_q[0].state, log_q[1].state, log_q[2].state, log_q[3].state}),
        32'o1235);
    chk("add_flag_en", 32'(log_q[2].flag_en), 32'd1);
    chk("add_alu_func", 32'(log_q[2].alu_func), 32'd1);
    chk("add_w_en", 32'({log_q[0].w_en, log_q[1].w_en, log_q[2].w_en, log_q[3].w_en}), 32'b0001);
    chk("add_retire", 32'({log_q[0].retire, log_q[1].retire, log_q[2].retire, log_q[3].retire}),
        32'b0001);

    // LD with three stalled memory cycles
    log_q.delete();
    do_instr(5'h8, 1'b0, 4'b0000, 0, 3, 1, 1'b1, 1'b0, st);
    chk("add_then_fetch", 32'(log_q[0].state), 32'd1);
    chk("ld_latency", 32'(log_q.size()), 32'd8);
    bits = '0;
    for (int k = 3; k < 7; k++)
      bits = {bits[28:0], log_q[k].mem_en, log_q[k].mem_sel, log_q[k].read_write};
    chk("ld_mem_strobes", bits, 32'hFFF);
    chk("ld_wb", 32'({log_q[7].state, log_q[7].w_en, log_q[7].retire}), 32'b10111);

    // ST with memory ready
    log_q.delete();
    do_instr(5'h9, 1'b1, 4'b0000, 0, 0, 1, 1'b1, 1'b0, st);
    chk("st_states", 32'({log_q[0].state, log_q[1].state, log_q[2].state, log_q[3].state}),
        32'o1234);
    chk("st_rw", 32'(log_q[3].read_write), 32'd0);
    chk("st_no_w_en", 32'(log_q[0].w_en | log_q[1].w_en | log_q[2].w_en | log_q[3].w_en), 32'd0);
    chk("st_retire", 32'(log_q[3].retire), 32'd1);

    // BE z=0, BE z=1, BNE z=1
    bits = '0;
    log_q.delete();
    do_instr(5'hB, 1'b0, 4'b0000, 0, 0, 1, 1'b1, 1'b0, st);
    bits = {bits[29:0], log_q[2].pc_load, log_q[2].retire};
    log_q.delete();
    do_instr(5'hB, 1'b0, 4'b0100, 0, 0, 1, 1'b1, 1'b0, st);
    bits = {bits[29:0], log_q[2].pc_load, log_q[2].retire};
    log_q.delete();
    do_instr(5'hC, 1'b0, 4'b0100, 0, 0, 1, 1'b1, 1'b0, st);
    bits = {bits[29:0], log_q[2].pc_load, log_q[2].retire};
    chk("branch_pc_load_retire", bits, 32'b01_11_01);

    // Ready arriving on the last allowed fetch cycle completes the access
    log_q.delete();
    do_instr(5'h1, 1'b0, 4'b0000, 3, 0, 1, 1'b1, 1'b0, st);
    chk("fetch_edge_ready", 32'({log_q[3].ir_load, log_q[4].state}), 32'b1010);

    // Fetch timeout, en toggling while faulted, then reset
    log_q.delete();
    do_instr(5'h4, 1'b0, 4'b0000, 9, 0, 1, 1'b1, 1'b0, st);
    fault_phase(5);
    chk("fetch_timeout_states",
        32'({log_q[0].state, log_q[1].state, log_q[2].state, log_q[3].state}), 32'o1111);
    bits = '0;
    for (int k = 4; k < 9; k++) bits = {bits[30:0], (log_q[k].state == 3'd7) && log_q[k].fault};
    chk("fault_sticky", bits, 32'b11111);
    do_reset();
    chk("reset_from_fault", 32'(act_o), 32'd0);
    idle_phase(1'b0);

    // Illegal opcode
    log_q.delete();
    do_instr(5'h12, 1'b1, 4'b1111, 0, 0, 1, 1'b1, 1'b0, st);
    fault_phase(6);
    chk("illegal_to_fault", 32'({log_q[1].state, log_q[2].state, log_q[2].fault}), 32'b0101111);
    bits = '0;
    for (int k = 2; k < 8; k++) bits[0] = bits[0] | log_q[k].w_en | log_q[k].pc_load | log_q[k].mem_en;
    chk("illegal_quiet", bits, 32'd0);
    do_reset();
    idle_phase(1'b0);

    // en dropped during an ADD: writeback still happens, then idle
    log_q.delete();
    do_instr(5'h2, 1'b0, 4'b1000, 0, 0, 0, 1'b0, 1'b0, st);
    idle_phase(1'b1);
    chk("en_drop_states",
        32'({log_q[0].state, log_q[1].state, log_q[2].state, log_q[3].state, log_q[4].state}),
        32'o12350);

    // Reset pulsed mid-memory, then restart
    do_instr(5'h8, 1'b0, 4'b0000, 0, 9, 1, 1'b1, 1'b1, st);
    chk("reset_mid_mem_status", 32'(st), 32'd2);
    log_q.delete();
    noise();
    reset = 1'b0;
    en = 1'b1;
    exp_o = zero_o(3'd0);
    step();
    do_instr(5'hF, 1'b0, 4'b0000, 0, 0, 1, 1'b1, 1'b0, st);
    chk("restart_states", 32'({log_q[0].state, log_q[1].state, log_q[2].state, log_q[3].state}),
        32'o0123);
    chk("cmp_flag_en", 32'({log_q[3].flag_en, log_q[3].retire}), 32'b11);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      rop = ($urandom_range(0, 39) == 0) ? OP_W'($urandom_range(16, 31))
                                         : OP_W'($urandom_range(0, 15));
      fw = pick_wait();
      mw = pick_wait();
      re = ($urandom_range(0, 3) != 0);
      do_instr(rop, 1'($urandom), 4'($urandom), fw, mw, 2, re, 1'b0, st);
      if (st == 1) begin
        fault_phase($urandom_range(1, 4));
        do_reset();
        idle_phase(1'b1);
      end else if (!re) begin
        idle_phase(1'b1);
      end
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
